// File: rtl/operand_issue_if.sv
// Decode, register-file, execute and writeback signals of the operand
// issue stage, bundled so the stage and its driver share one declaration.
interface operand_issue_if #(
  parameter int CTRL_W = 16
);
  logic              dec_valid_in;
  logic              dec_ready_out;
  logic [4:0]        dec_rs1_in;
  logic [4:0]        dec_rs2_in;
  logic [4:0]        dec_rd_in;
  logic              dec_use_rs1_in;
  logic              dec_use_rs2_in;
  logic              dec_wr_rd_in;
  logic [CTRL_W-1:0] dec_ctrl_in;
  logic [4:0]        rf_raddr1_out;
  logic [4:0]        rf_raddr2_out;
  logic [31:0]       rf_rdata1_in;
  logic [31:0]       rf_rdata2_in;
  logic              ex_valid_out;
  logic              ex_ready_in;
  logic [31:0]       ex_op1_out;
  logic [31:0]       ex_op2_out;
  logic [4:0]        ex_rd_out;
  logic              ex_wr_rd_out;
  logic [CTRL_W-1:0] ex_ctrl_out;
  logic              wb_valid_in;
  logic [4:0]        wb_rd_in;
  logic [31:0]       wb_data_in;
  logic              flush_in;
  logic [31:0]       busy_out;

  modport master (
    output dec_valid_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
    output dec_use_rs1_in, dec_use_rs2_in, dec_wr_rd_in, dec_ctrl_in,
    output rf_rdata1_in, rf_rdata2_in, ex_ready_in,
    output wb_valid_in, wb_rd_in, wb_data_in, flush_in,
    input  dec_ready_out, rf_raddr1_out, rf_raddr2_out,
    input  ex_valid_out, ex_op1_out, ex_op2_out,
    input  ex_rd_out, ex_wr_rd_out, ex_ctrl_out, busy_out
  );

  modport slave (
    input  dec_valid_in, dec_rs1_in, dec_rs2_in, dec_rd_in,
    input  dec_use_rs1_in, dec_use_rs2_in, dec_wr_rd_in, dec_ctrl_in,
    input  rf_rdata1_in, rf_rdata2_in, ex_ready_in,
    input  wb_valid_in, wb_rd_in, wb_data_in, flush_in,
    output dec_ready_out, rf_raddr1_out, rf_raddr2_out,
    output ex_valid_out, ex_op1_out, ex_op2_out,
    output ex_rd_out, ex_wr_rd_out, ex_ctrl_out, busy_out
  );
endinterface

// File: rtl/operand_issue.sv
// Operand fetch/issue stage: one decode slot, one output register and a
// 32-entry busy scoreboard with same-cycle writeback forwarding.
module operand_issue #(
  parameter int CTRL_W = 16
) (
  input logic clk,
  input logic rst,
  operand_issue_if.slave io
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              use1;
    logic              use2;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic [4:0]        rd;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;
  } out_t;

  slot_t       s_q;
  out_t        o_q;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        fwd1;
  logic        fwd2;
  logic        fwdd;
  logic        hazard;
  logic        move;
  logic        ex_hs;
  logic        dec_rdy;
  logic        dec_fire;
  logic        drop_o;

  always_comb begin
    fwd1 = io.wb_valid_in && (io.wb_rd_in == s_q.rs1);
    fwd2 = io.wb_valid_in && (io.wb_rd_in == s_q.rs2);
    fwdd = io.wb_valid_in && (io.wb_rd_in == s_q.rd);
    op1 = '0;
    op2 = '0;
    if (s_q.use1 && s_q.rs1 != 5'd0)
      op1 = fwd1 ? io.wb_data_in : io.rf_rdata1_in;
    if (s_q.use2 && s_q.rs2 != 5'd0)
      op2 = fwd2 ? io.wb_data_in : io.rf_rdata2_in;
    hazard =
      (s_q.use1 && s_q.rs1 != 5'd0 && busy_q[s_q.rs1] && !fwd1) ||
      (s_q.use2 && s_q.rs2 != 5'd0 && busy_q[s_q.rs2] && !fwd2) ||
      (s_q.wr && s_q.rd != 5'd0 && busy_q[s_q.rd] && !fwdd);
    move = s_q.valid && !hazard &&
           (!o_q.valid || io.ex_ready_in) && !io.flush_in;
    ex_hs = o_q.valid && io.ex_ready_in;
    dec_rdy = !rst && !io.flush_in && (!s_q.valid || move);
    dec_fire = io.dec_valid_in && dec_rdy;
    // An O entry taken by execute this cycle keeps its bit even under flush
    drop_o = io.flush_in && o_q.valid && !io.ex_ready_in &&
             o_q.wr && o_q.rd != 5'd0;
    busy_d = busy_q;
    if (drop_o)
      busy_d[o_q.rd] = 1'b0;
    if (io.wb_valid_in)
      busy_d[io.wb_rd_in] = 1'b0;
    if (move && s_q.wr && s_q.rd != 5'd0)
      busy_d[s_q.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      o_q    <= '0;
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (io.flush_in) begin
        s_q.valid <= 1'b0;
      end else if (dec_fire) begin
        s_q.valid <= 1'b1;
        s_q.rs1   <= io.dec_rs1_in;
        s_q.rs2   <= io.dec_rs2_in;
        s_q.rd    <= io.dec_rd_in;
        s_q.use1  <= io.dec_use_rs1_in;
        s_q.use2  <= io.dec_use_rs2_in;
        s_q.wr    <= io.dec_wr_rd_in;
        s_q.ctrl  <= io.dec_ctrl_in;
      end else if (move) begin
        s_q.valid <= 1'b0;
      end
      if (io.flush_in)
        o_q.valid <= 1'b0;
      else if (move)
        o_q <= {1'b1, op1, op2, s_q.rd, s_q.wr, s_q.ctrl};
      else if (ex_hs)
        o_q.valid <= 1'b0;
    end
  end

  assign io.dec_ready_out = dec_rdy;
  assign io.rf_raddr1_out = s_q.valid ? s_q.rs1 : 5'd0;
  assign io.rf_raddr2_out = s_q.valid ? s_q.rs2 : 5'd0;
  assign io.ex_valid_out  = o_q.valid;
  assign io.ex_op1_out    = o_q.op1;
  assign io.ex_op2_out    = o_q.op2;
  assign io.ex_rd_out     = o_q.rd;
  assign io.ex_wr_rd_out  = o_q.wr;
  assign io.ex_ctrl_out   = o_q.ctrl;
  assign io.busy_out      = busy_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: stimulus pushes expected issues into a
// queue, a negedge monitor pops and compares on every execute handshake.
module tb_operand_issue;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_issue_if #(.CTRL_W(16)) io ();

  operand_issue #(.CTRL_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a == 5'd0)
      return 32'hFFFF_FFFF;
    return 32'h11 * {27'd0, a};
  endfunction

  always_comb begin
    io.rf_rdata1_in = rf_val(io.rf_raddr1_out);
    io.rf_rdata2_in = rf_val(io.rf_raddr2_out);
  end

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wr;
    logic [15:0] ctrl;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && io.ex_valid_out && io.ex_ready_in) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: got rd %0d expected none",
                 io.ex_rd_out);
      end else begin
        e = q.pop_front();
        chk("mon_op1", io.ex_op1_out, e.op1);
        chk("mon_op2", io.ex_op2_out, e.op2);
        chk("mon_rd", {27'd0, io.ex_rd_out}, {27'd0, e.rd});
        chk("mon_wr", {31'd0, io.ex_wr_rd_out}, {31'd0, e.wr});
        chk("mon_ctrl", {16'd0, io.ex_ctrl_out}, {16'd0, e.ctrl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int k);
    while (cyc < k) step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1,
                       input logic u2, input logic wr,
                       input logic [15:0] ctrl, input logic [31:0] e1,
                       input logic [31:0] e2, input bit push);
    int n = 0;
    exp_t e;
    io.dec_valid_in   = 1'b1;
    io.dec_rs1_in     = rs1;
    io.dec_rs2_in     = rs2;
    io.dec_rd_in      = rd;
    io.dec_use_rs1_in = u1;
    io.dec_use_rs2_in = u2;
    io.dec_wr_rd_in   = wr;
    io.dec_ctrl_in    = ctrl;
    @(negedge clk);
    while (!io.dec_ready_out && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!io.dec_ready_out) begin
      tests++;
      fails++;
      $display("FAIL dec_timeout: got ready 0 expected 1 (rd %0d)", rd);
    end else begin
      last_hs = cyc;
      if (push) begin
        e.op1 = e1;
        e.op2 = e2;
        e.rd = rd;
        e.wr = wr;
        e.ctrl = ctrl;
        q.push_back(e);
      end
    end
    step();
    io.dec_valid_in = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] rd, input logic [31:0] d);
    io.wb_valid_in = 1'b1;
    io.wb_rd_in    = rd;
    io.wb_data_in  = d;
    step();
    io.wb_valid_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int h;
    int h2;
    rst = 1'b1;
    io.dec_valid_in = 0;
    io.dec_rs1_in = 0;
    io.dec_rs2_in = 0;
    io.dec_rd_in = 0;
    io.dec_use_rs1_in = 0;
    io.dec_use_rs2_in = 0;
    io.dec_wr_rd_in = 0;
    io.dec_ctrl_in = 0;
    io.ex_ready_in = 1'b1;
    io.wb_valid_in = 0;
    io.wb_rd_in = 0;
    io.wb_data_in = 0;
    io.flush_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_ready", {31'd0, io.dec_ready_out}, 0);
    chk("rst_ex_valid", {31'd0, io.ex_valid_out}, 0);
    chk("rst_busy", io.busy_out, 0);
    chk("rst_op1", io.ex_op1_out, 0);
    chk("rst_raddr1", {27'd0, io.rf_raddr1_out}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, io.dec_ready_out}, 1);
    step();

    // basic latency and busy set
    issue(1, 2, 3, 1, 1, 1, 16'hA001, 32'h11, 32'h22, 1);
    h = last_hs;
    at_neg(h + 1);
    chk("lat_c1_valid", {31'd0, io.ex_valid_out}, 0);
    step();
    at_neg(h + 2);
    chk("lat_c2_valid", {31'd0, io.ex_valid_out}, 1);
    step();
    at_neg(h + 3);
    chk("busy_x3", io.busy_out, 32'h0000_0008);
    step();
    wb_pulse(3, 32'h3);
    @(negedge clk);
    chk("busy_x3_clr", io.busy_out, 0);
    step();

    // back-to-back independent
    issue(1, 2, 5, 1, 1, 1, 16'hB005, 32'h11, 32'h22, 1);
    h = last_hs;
    issue(3, 4, 6, 1, 1, 1, 16'hB006, 32'h33, 32'h44, 1);
    h2 = last_hs;
    chk("b2b_hs_gap", h2 - h, 1);
    at_neg(h + 2);
    chk("b2b_valid0", {31'd0, io.ex_valid_out}, 1);
    step();
    at_neg(h + 3);
    chk("b2b_valid1", {31'd0, io.ex_valid_out}, 1);
    step();
    at_neg(h + 4);
    chk("b2b_busy", io.busy_out, 32'h0000_0060);
    step();
    wb_pulse(5, 32'h5);
    wb_pulse(6, 32'h6);
    @(negedge clk);
    chk("b2b_busy_clr", io.busy_out, 0);
    step();

    // RAW on x7 resolved by forwarding
    issue(1, 2, 7, 1, 1, 1, 16'hC007, 32'h11, 32'h22, 1);
    issue(7, 0, 8, 1, 0, 1, 16'hC008, 32'hDEAD_BEEF, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("raw_stall", {31'd0, io.dec_ready_out}, 0);
      step();
    end
    chk("raw_busy7", io.busy_out, 32'h0000_0080);
    io.wb_valid_in = 1'b1;
    io.wb_rd_in = 7;
    io.wb_data_in = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_move", {31'd0, io.dec_ready_out}, 1);
    step();
    io.wb_valid_in = 1'b0;
    @(negedge clk);
    chk("raw_ex_valid", {31'd0, io.ex_valid_out}, 1);
    chk("raw_busy", io.busy_out, 32'h0000_0100);
    step();
    wb_pulse(8, 32'h8);
    @(negedge clk);
    chk("raw_busy_clr", io.busy_out, 0);
    step();

    // x0 sources forced to zero, rd=0 never busy
    io.wb_valid_in = 1'b1;
    io.wb_rd_in = 0;
    io.wb_data_in = 32'h5;
    issue(0, 0, 0, 1, 1, 1, 16'hD000, 32'h0, 32'h0, 1);
    h = last_hs;
    at_neg(h + 2);
    chk("x0_valid", {31'd0, io.ex_valid_out}, 1);
    chk("x0_busy", io.busy_out, 0);
    step();
    io.wb_valid_in = 1'b0;

    // backpressure with S and O full
    io.ex_ready_in = 1'b0;
    issue(1, 2, 11, 1, 1, 1, 16'hE011, 32'h11, 32'h22, 1);
    issue(3, 4, 12, 1, 1, 1, 16'hE012, 32'h33, 32'h44, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, io.ex_valid_out}, 1);
      chk("bp_op1", io.ex_op1_out, 32'h11);
      chk("bp_rd", {27'd0, io.ex_rd_out}, 11);
      chk("bp_ctrl", {16'd0, io.ex_ctrl_out}, 32'h0000_E011);
      chk("bp_dec_ready", {31'd0, io.dec_ready_out}, 0);
      step();
    end
    io.ex_ready_in = 1'b1;
    @(negedge clk);
    chk("drain0_rd", {27'd0, io.ex_rd_out}, 11);
    step();
    @(negedge clk);
    chk("drain1_rd", {27'd0, io.ex_rd_out}, 12);
    step();
    wb_pulse(11, 32'hB);
    wb_pulse(12, 32'hC);

    // flush with unaccepted x9 in O and x10 in S; x13 already accepted
    issue(1, 2, 13, 1, 1, 1, 16'hF013, 32'h11, 32'h22, 1);
    h = last_hs;
    at_neg(h + 3);
    chk("fl_busy13", io.busy_out, 32'h0000_2000);
    step();
    io.ex_ready_in = 1'b0;
    issue(1, 2, 9, 1, 1, 1, 16'hF009, 32'h11, 32'h22, 0);
    issue(3, 4, 10, 1, 1, 1, 16'hF010, 32'h33, 32'h44, 0);
    @(negedge clk);
    chk("fl_pre_busy", io.busy_out, 32'h0000_2200);
    chk("fl_pre_valid", {31'd0, io.ex_valid_out}, 1);
    step();
    io.flush_in = 1'b1;
    io.dec_valid_in = 1'b1;
    @(negedge clk);
    chk("fl_dec_ready", {31'd0, io.dec_ready_out}, 0);
    step();
    io.flush_in = 1'b0;
    io.dec_valid_in = 1'b0;
    @(negedge clk);
    chk("fl_ex_valid", {31'd0, io.ex_valid_out}, 0);
    chk("fl_busy", io.busy_out, 32'h0000_2000);
    chk("fl_raddr1", {27'd0, io.rf_raddr1_out}, 0);
    step();
    io.ex_ready_in = 1'b1;
    wb_pulse(13, 32'hD);
    @(negedge clk);
    chk("end_busy", io.busy_out, 0);
    step();
    repeat (3) step();
    chk("end_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand-fetch/issue stage between decode and execute. Holds one decoded instruction, drives the integer register file read addresses, and forwards same-cycle writeback data. A 32-entry scoreboard enforces RAW/WAW ordering. Issues operands to execute through a registered valid/ready output.

## Interface
Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed through to execute

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- dec_valid_in  in  1  decode offers an instruction
- dec_ready_out  out  1  stage accepts this cycle
- dec_rs1_in, dec_rs2_in, dec_rd_in  in  5 each  register indices
- dec_use_rs1_in, dec_use_rs2_in  in  1 each  source is read
- dec_wr_rd_in  in  1  instruction writes rd
- dec_ctrl_in  in  CTRL_W  opaque control
- rf_raddr1_out, rf_raddr2_out  out  5 each  register file read addresses
- rf_rdata1_in, rf_rdata2_in  in  32 each  combinational register file read data
- ex_valid_out  out  1  operands valid to execute
- ex_ready_in  in  1  execute accepts
- ex_op1_out, ex_op2_out  out  32 each  resolved operands
- ex_rd_out  out  5; ex_wr_rd_out  out  1; ex_ctrl_out  out  CTRL_W
- wb_valid_in  in  1  writeback commits this cycle; same signal as register file wen
- wb_rd_in  in  5; wb_data_in  in  32  writeback address/data
- flush_in  in  1  discard everything not yet accepted by execute
- busy_out  out  32  scoreboard vector (debug/perf)

## Operation
- Two elastic registers: slot (S, fed by decode) and output (O, drives ex_*).
- Decode handshake: dec_valid_in & dec_ready_out. dec_ready_out = !rst & !flush_in & (!S.valid | S moves to O this cycle).
- rf_raddr1/2_out = S.rs1/S.rs2 when S.valid, else 0.
- Operand resolve per source:
  - rs==0 or !use gives 0. x0 is always forced to 0; register-file x0 content is ignored.
  - Otherwise, wb_valid_in & wb_rd_in==rs gives wb_data_in (forward).
  - Otherwise, rf_rdata.
- Hazard for S:
  - RAW: use_rsN & rsN!=0 & busy[rsN] & !(wb_valid_in & wb_rd_in==rsN).
  - WAW: wr_rd & rd!=0 & busy[rd] & !(wb_valid_in & wb_rd_in==rd).
- Move S→O when S.valid & !hazard & (!O.valid | ex_ready_in) & !flush_in.
- O clears on an ex handshake with no move.
- Scoreboard:
  - busy[0] is hardwired 0.
  - A move with wr_rd & rd!=0 sets busy[rd].
  - wb_valid_in clears busy[wb_rd_in]. A clear of a non-busy register is a no-op.
  - If a set and a clear hit the same index in one cycle, set wins.
- Flush:
  - S.valid and O.valid are cleared.
  - If O.valid & O.wr_rd & O.rd!=0, busy[O.rd] is cleared.
  - A wb in the same cycle still clears its bit.
  - Instructions already accepted by execute keep their busy bits.
- Stall on ex_ready_in=0: O and all ex_* outputs are held stable while ex_valid_out=1.

## Timing
- Reset (async assert, sync deassert at the next clk edge):
  - S.valid=O.valid=0 and busy=0.
  - ex_valid_out=0; ex_op*/ex_rd/ex_ctrl/ex_wr_rd=0; rf_raddr*=0; busy_out=0.
  - dec_ready_out=0 while rst is high and 1 in the first cycle after.
- Latency: decode handshake in cycle c, no hazard, O empty gives ex_valid_out=1 in cycle c+2.
- Throughput: 1 instruction/cycle with independent registers and ex_ready_in=1.
- Dependent instruction: if the producer's wb_valid_in occurs in cycle w, the consumer moves at the end of w (forwarded data) and ex_valid_out=1 in w+1.
- Reset mid-operation drops S and O immediately; no ex_valid_out glitch.
- Flush wins over a move and over a decode handshake in the same cycle.

## Test plan
- Reset, then issue `rs1=1, rs2=2, rd=3` with rf_rdata=0x11/0x22:
  - ex_valid_out rises 2 cycles after the handshake with op1=0x11, op2=0x22.
  - busy_out=0x0000_0008 after the ex handshake.
- Back-to-back independent x5←(x1,x2) and x6←(x3,x4), ex_ready_in=1:
  - ex_valid_out high on consecutive cycles.
  - busy_out=0x60.
- RAW: x7 written, then a consumer of rs1=7:
  - Consumer stalls (dec_ready_out=0) until wb_valid_in, wb_rd_in=7, wb_data_in=0xDEAD_BEEF.
  - Same cycle it moves; next cycle ex_op1_out=0xDEAD_BEEF and busy[7]=0.
- x0 handling: rs1=0 with rf_rdata1=0xFFFF_FFFF and wb_rd_in=0, wb_data_in=5:
  - op1=0.
  - rd=0 issue leaves busy_out=0.
- Backpressure: ex_ready_in=0 for 4 cycles with S and O full:
  - ex_* outputs stable.
  - dec_ready_out=0.
  - Resume drains both in order.
- Flush with O holding rd=9 and S holding rd=10, both unaccepted:
  - Next cycle ex_valid_out=0 and busy[9]=0.
  - busy bits of instructions already accepted by execute are unchanged.
